// File: rtl/softex_tcdm_responder_pkg.sv
// Shared constants, response record and LFSR step for the banked TCDM responder.
// Imported by the interface, the round-robin arbiter and the responder top.
package softex_tcdm_responder_pkg;

  localparam int          TCDM_RESP_N_BANKS_DEF    = 8;
  localparam int          TCDM_RESP_BANK_WORDS_DEF = 256;
  localparam logic [15:0] TCDM_RESP_LFSR_SEED      = 16'hACE1;
  localparam int          TCDM_RESP_ID_W           = 8;

  typedef struct packed {
    logic [31:0]               data;
    logic [TCDM_RESP_ID_W-1:0] id;
    logic                      opc;
  } tcdm_resp_t;

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB.
  function automatic logic [15:0] lfsrNext(input logic [15:0] state);
    return {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
  endfunction

endpackage

// File: rtl/softex_tcdm_responder_if.sv
// Bundle of the MP request/response TCDM ports; master = streamer side,
// slave = memory (responder) side.
interface softex_tcdm_responder_if
  import softex_tcdm_responder_pkg::*;
#(
  parameter int MP   = 4,
  parameter int ID_W = TCDM_RESP_ID_W
);

  logic [MP-1:0]           req;
  logic [MP-1:0]           gnt;
  logic [MP-1:0][31:0]     add;
  logic [MP-1:0]           wen;
  logic [MP-1:0][3:0]      be;
  logic [MP-1:0][31:0]     data;
  logic [MP-1:0][ID_W-1:0] id;
  logic [MP-1:0]           rReady;
  logic [MP-1:0]           rValid;
  logic [MP-1:0][31:0]     rData;
  logic [MP-1:0][ID_W-1:0] rId;
  logic [MP-1:0]           rOpc;

  modport master (
    output req, add, wen, be, data, id, rReady,
    input  gnt, rValid, rData, rId, rOpc
  );

  modport slave (
    input  req, add, wen, be, data, id, rReady,
    output gnt, rValid, rData, rId, rOpc
  );

endinterface

// File: rtl/softex_tcdm_rr_arbiter.sv
// Round-robin arbiter for one bank: one-hot combinational grant starting at
// the pointer; after a grant the pointer moves to the port after the winner.
module softex_tcdm_rr_arbiter
  import softex_tcdm_responder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  logic             found;

  function automatic int wrapIdx(input int base, input int offs);
    int s;
    s = base + offs;
    if (s >= N) s = s - N;
    return s;
  endfunction

  // Scan ports starting at the pointer; the first requester wins.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'(wrapIdx(int'(ptr_q), i));
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = (int'(idx) == N - 1) ? '0 : idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  grantOneHot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));

endmodule

// File: rtl/softex_tcdm_responder.sv
// Word-interleaved, multi-bank TCDM responder with per-port response buffers.
// Optional macro SOFTEX_TCDM_RESP_STALL_EN adds LFSR-driven grant stalls.
module softex_tcdm_responder
  import softex_tcdm_responder_pkg::*;
#(
  parameter int MP         = 4,
  parameter int N_BANKS    = TCDM_RESP_N_BANKS_DEF,
  parameter int BANK_WORDS = TCDM_RESP_BANK_WORDS_DEF,
  parameter int ID_W       = TCDM_RESP_ID_W
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  softex_tcdm_responder_if.slave tcdm
);

  localparam int BANK_W = $clog2(N_BANKS);
  localparam int ROW_W  = $clog2(BANK_WORDS);
  localparam int WORD_W = BANK_W + ROW_W;

  logic [MP-1:0][BANK_W-1:0]   bankSel;
  logic [MP-1:0][ROW_W-1:0]    rowSel;
  logic [MP-1:0]               outOfRange;
  logic [MP-1:0]               stall;
  logic [MP-1:0]               eligible;
  logic [MP-1:0]               gnt;
  logic [N_BANKS-1:0][MP-1:0]  bankReq;
  logic [N_BANKS-1:0][MP-1:0]  bankGnt;
  logic                        unusedAddBits;

  logic [31:0]                 mem_q [N_BANKS][BANK_WORDS];
  logic [MP-1:0]               rValid_q, rValid_d;
  tcdm_resp_t [MP-1:0]         resp_q, resp_d;

  logic [MP-1:0][31:0]         rDataOut;
  logic [MP-1:0][ID_W-1:0]     rIdOut;
  logic [MP-1:0]               rOpcOut;

  // Low bits pick the bank, the next ones the row; anything above is out of range.
  always_comb begin
    unusedAddBits = 1'b0;
    for (int p = 0; p < MP; p++) begin
      bankSel[p]    = tcdm.add[p][2 +: BANK_W];
      rowSel[p]     = tcdm.add[p][2 + BANK_W +: ROW_W];
      outOfRange[p] = (tcdm.add[p] >> (2 + WORD_W)) != 32'd0;
      unusedAddBits = unusedAddBits ^ (^tcdm.add[p][1:0]);
    end
  end

`ifdef SOFTEX_TCDM_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = lfsrNext(lfsr_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= TCDM_RESP_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  for (genvar g = 0; g < MP; g++) begin : gen_stall
    assign stall[g] = lfsr_q[g % 16];
  end
`else
  assign stall = '0;
`endif

  // A port may compete only if its response slot is free or drains this cycle.
  always_comb begin
    eligible = '0;
    bankReq  = '0;
    for (int p = 0; p < MP; p++) begin
      eligible[p] = rst_ni && tcdm.req[p] && (!rValid_q[p] || tcdm.rReady[p]) && !stall[p];
      for (int b = 0; b < N_BANKS; b++) begin
        bankReq[b][p] = eligible[p] && (bankSel[p] == BANK_W'(b));
      end
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : gen_bank_arb
    softex_tcdm_rr_arbiter #(
      .N (MP)
    ) i_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (bankReq[b]),
      .gnt_o  (bankGnt[b])
    );
  end

  always_comb begin
    gnt = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      gnt = gnt | bankGnt[b];
    end
  end

  // A grant loads the slot; otherwise an accepted response empties it.
  always_comb begin
    rValid_d = rValid_q;
    resp_d   = resp_q;
    for (int p = 0; p < MP; p++) begin
      if (gnt[p]) begin
        rValid_d[p]    = 1'b1;
        resp_d[p].data = tcdm.wen[p] ? mem_q[bankSel[p]][rowSel[p]] : 32'd0;
        resp_d[p].id   = TCDM_RESP_ID_W'(tcdm.id[p]);
        resp_d[p].opc  = outOfRange[p];
      end else if (tcdm.rReady[p]) begin
        rValid_d[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rValid_q <= '0;
      resp_q   <= '0;
    end else begin
      rValid_q <= rValid_d;
      resp_q   <= resp_d;
    end
  end

  // At most one grant per bank, so two writes never target the same word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < N_BANKS; b++) begin
        for (int w = 0; w < BANK_WORDS; w++) begin
          mem_q[b][w] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < MP; p++) begin
        if (gnt[p] && !tcdm.wen[p]) begin
          for (int i = 0; i < 4; i++) begin
            if (tcdm.be[p][i]) begin
              mem_q[bankSel[p]][rowSel[p]][8*i +: 8] <= tcdm.data[p][8*i +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    rDataOut = '0;
    rIdOut   = '0;
    rOpcOut  = '0;
    for (int p = 0; p < MP; p++) begin
      rDataOut[p] = resp_q[p].data;
      rIdOut[p]   = ID_W'(resp_q[p].id);
      rOpcOut[p]  = resp_q[p].opc;
    end
  end

  assign tcdm.gnt    = gnt;
  assign tcdm.rValid = rValid_q;
  assign tcdm.rData  = rDataOut;
  assign tcdm.rId    = rIdOut;
  assign tcdm.rOpc   = rOpcOut;

endmodule

// File: tb/tb_softex_tcdm_responder.sv
// Directed bench for softex_tcdm_responder; with SOFTEX_TCDM_RESP_STALL_EN it
// runs a random single-port data-integrity sequence instead.
module tb_softex_tcdm_responder;
  import softex_tcdm_responder_pkg::*;

  localparam int MP         = 4;
  localparam int N_BANKS    = 8;
  localparam int BANK_WORDS = 256;
  localparam int ID_W       = 8;

  logic clk_i;
  logic rst_ni;
  int   compared;
  int   mismatched;

  softex_tcdm_responder_if #(.MP(MP), .ID_W(ID_W)) tcdm ();

  softex_tcdm_responder #(
    .MP         (MP),
    .N_BANKS    (N_BANKS),
    .BANK_WORDS (BANK_WORDS),
    .ID_W       (ID_W)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tcdm   (tcdm.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int p, input logic rq, input logic [31:0] addr, input logic wen,
                               input logic [3:0] be, input logic [31:0] wdata, input logic [7:0] id);
    tcdm.req[p]  = rq;
    tcdm.add[p]  = addr;
    tcdm.wen[p]  = wen;
    tcdm.be[p]   = be;
    tcdm.data[p] = wdata;
    tcdm.id[p]   = id;
  endtask

  task automatic clearAll();
    for (int p = 0; p < MP; p++) applyStimulus(p, 1'b0, 32'd0, 1'b1, 4'h0, 32'd0, 8'd0);
    tcdm.rReady = '1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

`ifdef SOFTEX_TCDM_RESP_STALL_EN
  logic [31:0] model [64];
  int          stalls [MP];
  int          opPort, opWord, waitCnt;
  logic        opWrite;
  logic [3:0]  opBe;
  logic [31:0] opData, expData;
  logic [7:0]  opId;
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_ni     = 1'b0;
    clearAll();
    repeat (2) @(posedge clk_i);
    #1;
    applyStimulus(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'd0, 8'd1);
    #1;
    checkOutput("reset_gnt", tcdm.gnt, 4'b0000);
    checkOutput("reset_rvalid", tcdm.rValid, 4'b0000);
    checkOutput("reset_rdata0", tcdm.rData[0], 32'd0);
    checkOutput("reset_ropc", tcdm.rOpc, 4'b0000);
    clearAll();
    rst_ni = 1'b1;
    tick();

`ifdef SOFTEX_TCDM_RESP_STALL_EN
    for (int w = 0; w < 64; w++) model[w] = 32'd0;
    for (int p = 0; p < MP; p++) stalls[p] = 0;
    for (int n = 0; n < 1000; n++) begin
      opPort  = $urandom_range(MP - 1, 0);
      opWord  = $urandom_range(63, 0);
      opWrite = 1'($urandom_range(1, 0));
      opBe    = 4'($urandom_range(15, 0));
      opData  = $urandom;
      opId    = n[7:0];
      applyStimulus(opPort, 1'b1, 32'(opWord * 4), !opWrite, opBe, opData, opId);
      waitCnt = 0;
      #1;
      while (!tcdm.gnt[opPort] && waitCnt < 64) begin
        stalls[opPort]++;
        waitCnt++;
        tick();
        #1;
      end
      checkOutput("stall_gnt", tcdm.gnt[opPort], 1'b1);
      tick();
      expData = opWrite ? 32'd0 : model[opWord];
      if (opWrite) begin
        for (int i = 0; i < 4; i++) if (opBe[i]) model[opWord][8*i +: 8] = opData[8*i +: 8];
      end
      checkOutput("stall_rvalid", tcdm.rValid[opPort], 1'b1);
      checkOutput("stall_rdata", tcdm.rData[opPort], expData);
      checkOutput("stall_rid", tcdm.rId[opPort], opId);
      applyStimulus(opPort, 1'b0, 32'd0, 1'b1, 4'h0, 32'd0, 8'd0);
    end
    for (int p = 0; p < MP; p++) checkOutput("stall_seen", stalls[p] > 0, 1'b1);
`else
    // single write then read on port 0
    applyStimulus(0, 1'b1, 32'h40, 1'b0, 4'hF, 32'hDEADBEEF, 8'd3);
    #1;
    checkOutput("wr_gnt", tcdm.gnt, 4'b0001);
    tick();
    checkOutput("wr_ack_valid", tcdm.rValid, 4'b0001);
    checkOutput("wr_ack_data", tcdm.rData[0], 32'd0);
    checkOutput("wr_ack_id", tcdm.rId[0], 8'd3);
    applyStimulus(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'd0, 8'd4);
    #1;
    checkOutput("rd_gnt", tcdm.gnt, 4'b0001);
    tick();
    checkOutput("rd_valid", tcdm.rValid, 4'b0001);
    checkOutput("rd_data", tcdm.rData[0], 32'hDEADBEEF);
    checkOutput("rd_id", tcdm.rId[0], 8'd4);
    checkOutput("rd_opc", tcdm.rOpc[0], 1'b0);

    // byte enables
    applyStimulus(0, 1'b1, 32'h40, 1'b0, 4'b0101, 32'h11223344, 8'd5);
    #1;
    checkOutput("be_wr_gnt", tcdm.gnt, 4'b0001);
    tick();
    applyStimulus(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'd0, 8'd6);
    tick();
    checkOutput("be_rd_data", tcdm.rData[0], 32'hDE22BE44);

    // reset pulse while a response is pending
    applyStimulus(0, 1'b0, 32'd0, 1'b1, 4'h0, 32'd0, 8'd0);
    rst_ni = 1'b0;
    #1;
    checkOutput("midreset_rvalid", tcdm.rValid, 4'b0000);
    checkOutput("midreset_rdata", tcdm.rData[0], 32'd0);
    #1;
    rst_ni = 1'b1;
    tick();

    // bank conflict: four ports on word 0, two bursts
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < MP; p++) applyStimulus(p, 1'b1, 32'h0, 1'b1, 4'h0, 32'd0, 8'(p));
      for (int k = 0; k < MP; k++) begin
        #1;
        checkOutput("conflict_gnt", tcdm.gnt, 64'd1 << k);
        tick();
        checkOutput("conflict_rvalid", tcdm.rValid, 64'd1 << k);
        checkOutput("conflict_rid", tcdm.rId[k], 8'(k));
        applyStimulus(k, 1'b0, 32'd0, 1'b1, 4'h0, 32'd0, 8'd0);
      end
    end

    // conflict-free: four distinct banks written then read in one cycle each
    for (int p = 0; p < MP; p++)
      applyStimulus(p, 1'b1, 32'(p * 4), 1'b0, 4'hF, 32'hA0000000 | 32'(p), 8'(8'h10 + p));
    #1;
    checkOutput("cf_wr_gnt", tcdm.gnt, 4'b1111);
    tick();
    checkOutput("cf_wr_rvalid", tcdm.rValid, 4'b1111);
    for (int p = 0; p < MP; p++)
      applyStimulus(p, 1'b1, 32'(p * 4), 1'b1, 4'h0, 32'd0, 8'(8'h20 + p));
    #1;
    checkOutput("cf_rd_gnt", tcdm.gnt, 4'b1111);
    tick();
    checkOutput("cf_rd_rvalid", tcdm.rValid, 4'b1111);
    for (int p = 0; p < MP; p++) begin
      checkOutput("cf_rd_data", tcdm.rData[p], 32'hA0000000 | 32'(p));
      checkOutput("cf_rd_id", tcdm.rId[p], 8'(8'h20 + p));
    end
    clearAll();
    tick();
    checkOutput("cf_drain", tcdm.rValid, 4'b0000);

    // backpressure on port 1
    tcdm.rReady[1] = 1'b0;
    applyStimulus(1, 1'b1, 32'h04, 1'b1, 4'h0, 32'd0, 8'h21);
    #1;
    checkOutput("bp_gnt1", tcdm.gnt, 4'b0010);
    tick();
    applyStimulus(1, 1'b1, 32'h08, 1'b1, 4'h0, 32'd0, 8'h22);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_hold_valid", tcdm.rValid[1], 1'b1);
      checkOutput("bp_hold_id", tcdm.rId[1], 8'h21);
      checkOutput("bp_hold_data", tcdm.rData[1], 32'hA0000001);
      #1;
      checkOutput("bp_no_gnt", tcdm.gnt, 4'b0000);
      tick();
    end
    tcdm.rReady[1] = 1'b1;
    #1;
    checkOutput("bp_gnt2", tcdm.gnt, 4'b0010);
    tick();
    checkOutput("bp_resp2_valid", tcdm.rValid[1], 1'b1);
    checkOutput("bp_resp2_id", tcdm.rId[1], 8'h22);
    checkOutput("bp_resp2_data", tcdm.rData[1], 32'hA0000002);
    applyStimulus(1, 1'b0, 32'd0, 1'b1, 4'h0, 32'd0, 8'd0);
    tick();
    checkOutput("bp_drain", tcdm.rValid[1], 1'b0);

    // out-of-range read and write wrap onto the row and flag opc
    applyStimulus(0, 1'b1, 32'h2000, 1'b1, 4'h0, 32'd0, 8'h30);
    #1;
    checkOutput("oor_rd_gnt", tcdm.gnt, 4'b0001);
    tick();
    checkOutput("oor_rd_opc", tcdm.rOpc[0], 1'b1);
    checkOutput("oor_rd_data", tcdm.rData[0], 32'hA0000000);
    applyStimulus(0, 1'b1, 32'h2004, 1'b0, 4'hF, 32'h5555AAAA, 8'h31);
    tick();
    checkOutput("oor_wr_opc", tcdm.rOpc[0], 1'b1);
    checkOutput("oor_wr_data", tcdm.rData[0], 32'd0);
    applyStimulus(0, 1'b1, 32'h04, 1'b1, 4'h0, 32'd0, 8'h32);
    tick();
    checkOutput("oor_alias_data", tcdm.rData[0], 32'h5555AAAA);
    checkOutput("oor_alias_opc", tcdm.rOpc[0], 1'b0);

    // word written before the reset pulse must read back cleared
    applyStimulus(0, 1'b1, 32'h40, 1'b1, 4'h0, 32'd0, 8'h33);
    tick();
    checkOutput("postreset_mem", tcdm.rData[0], 32'd0);
    checkOutput("postreset_id", tcdm.rId[0], 8'h33);
`endif

    clearAll();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
